l2_cache: RTL and testbench
===========================

// Module: l2_cache
// PURPOSE
//  Unified direct-mapped write-back L2 cache. Upstream it serves the single line-wide request
//  port driven by the I/D cache arbiter. Downstream it issues line-wide reads and writebacks
//  to physical memory. Full 256-bit lines on both sides; no sub-line masking.
// PARAMETERS
//  s_offset  5                         byte-offset bits per line (32-byte lines)
//  s_index   4                         index bits (16 sets)
//  s_tag     32-s_offset-s_index       tag bits
//  s_mask    2**s_offset               bytes per line
//  s_line    8*s_mask                  line width in bits (256)
// PORTS
//  clk          in   1       clock; all state updates on posedge
//  rst_n        in   1       synchronous active-low reset
//  mem_read     in   1       line read request from arbiter; held until mem_resp
//  mem_write    in   1       full-line write request from arbiter; held until mem_resp
//  mem_address  in   32      request byte address; low s_offset bits ignored
//  mem_wdata    in   s_line  write line
//  mem_resp     out  1       one-cycle completion pulse
//  mem_rdata    out  s_line  read line; valid only while mem_resp=1
//  pmem_read    out  1       line fill request; held until pmem_resp
//  pmem_write   out  1       writeback request; held until pmem_resp
//  pmem_address out  32      line-aligned address (low s_offset bits = 0)
//  pmem_wdata   out  s_line  writeback line
//  pmem_resp    in   1       physical memory completion, one cycle
//  pmem_rdata   in   s_line  fill data; valid with pmem_resp
// BEHAVIOUR
//  Storage: per set data[s_line], tag[s_tag], valid, dirty. Only valid and dirty are reset.
//  Request latch: in IDLE, mem_read|mem_write captures address, wdata and op into request regs.
//   read&write together: treated as a write.
//  Address split: tag=addr[31:s_offset+s_index], idx=addr[s_offset+s_index-1:s_offset].
//   hit = valid[idx] && tag[idx]==req_tag.
//  FSM states IDLE, TAG_CHECK, WRITEBACK, FILL:
//   IDLE: request -> TAG_CHECK. Otherwise stay.
//   TAG_CHECK:
//    read hit: mem_resp=1, mem_rdata=data[idx] -> IDLE.
//    write hit: data<=wdata, dirty<=1, mem_resp=1 -> IDLE.
//    write miss, line clean or invalid: install data/tag, valid<=1, dirty<=1, mem_resp=1 -> IDLE.
//     No fill (full-line write).
//    miss with valid&dirty -> WRITEBACK.
//    read miss, line clean -> FILL.
//   WRITEBACK: pmem_write=1, pmem_address={tag[idx],idx,0}, pmem_wdata=data[idx].
//    On pmem_resp: dirty<=0, then write op -> TAG_CHECK, read op -> FILL.
//   FILL: pmem_read=1, pmem_address={req_tag,idx,0}.
//    On pmem_resp: data<=pmem_rdata, tag<=req_tag, valid<=1, dirty<=0 -> TAG_CHECK (now hits).
//  Latency:
//   hit or clean write miss: request seen in cycle 0, mem_resp in cycle 1.
//   misses: add one pmem transaction each for writeback and fill, plus one TAG_CHECK cycle.
//  Outputs are decoded from state plus request regs and are stable while pmem_* is held.
//   pmem_read and pmem_write are never both 1.
//  mem_resp is a single pulse. The upstream port deasserts its request the cycle after the pulse,
//   so IDLE never re-accepts a completed request.
//  Reset (rst_n=0 at posedge): state<=IDLE; all valid and dirty bits <=0.
//   Cycle after reset: mem_resp=0, pmem_read=0, pmem_write=0.
//  Reset mid-operation: any in-flight pmem transaction is abandoned.
//   No mem_resp is issued for the aborted request.
//   A pmem_resp arriving after reset is ignored in IDLE.
//  pmem_resp outside WRITEBACK/FILL: ignored.
//  Data arrays: written only in TAG_CHECK (write hit or install) and FILL completion.
// TESTING
//  1 Cold read miss: reset; read 0x0000_0040; pmem_resp with line A after 5 cycles
//    -> pmem_read addr 0x40, then mem_resp=1 with rdata=A.
//  2 Read hit: re-read 0x44 -> mem_resp in the cycle after the request, rdata=A,
//    no pmem_read/pmem_write.
//  3 Dirty eviction: write B to 0x40 (hit, 1-cycle resp), then read 0x240 (same idx 2)
//    -> pmem_write addr 0x40 wdata=B, then pmem_read addr 0x240, then mem_resp with fill data.
//  4 Clean write miss: write C to 0x80 after reset -> mem_resp next cycle, no pmem traffic.
//    Then read 0x280 -> pmem_write 0x80 wdata=C before the fill.
//  5 Reset in FILL: assert rst_n=0 while pmem_read=1 -> pmem_read=0 next cycle, no mem_resp.
//    Read 0x40 after reset misses again.
//  6 Slow memory: pmem_resp delayed 20 cycles -> pmem_read, pmem_address and mem_resp=0 stay stable
//    throughout. Read+write together -> handled as a write.

Source files
------------

// File: rtl/l2_cache_if.sv
// Line-wide request port from the I/D arbiter plus the physical-memory port of the L2.
// The cache attaches through the slave modport; the arbiter/memory side uses master.
interface l2_cache_if #(
  parameter int s_line = 256
);
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_address;
  logic [s_line-1:0] mem_wdata;
  logic              mem_resp;
  logic [s_line-1:0] mem_rdata;
  logic              pmem_read;
  logic              pmem_write;
  logic [31:0]       pmem_address;
  logic [s_line-1:0] pmem_wdata;
  logic              pmem_resp;
  logic [s_line-1:0] pmem_rdata;

  modport slave (
    input  mem_read, mem_write, mem_address, mem_wdata, pmem_resp, pmem_rdata,
    output mem_resp, mem_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output mem_read, mem_write, mem_address, mem_wdata, pmem_resp, pmem_rdata,
    input  mem_resp, mem_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/l2_cache.sv
// Unified direct-mapped write-back L2 cache with full-line upstream and downstream ports.
// Line data sits in an array with a registered read, so the selected line is fetched in IDLE.
module l2_cache #(
  parameter int s_offset = 5,
  parameter int s_index  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  l2_cache_if.slave  bus
);
  localparam int s_tag  = 32 - s_offset - s_index;
  localparam int s_mask = 2 ** s_offset;
  localparam int s_line = 8 * s_mask;
  localparam int s_sets = 2 ** s_index;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TAG_CHECK,
    ST_WRITEBACK,
    ST_FILL
  } state_t;

  state_t            r_state;
  logic [s_tag-1:0]  r_req_tag;
  logic [s_index-1:0] r_req_idx;
  logic [s_line-1:0] r_req_wdata;
  logic              r_req_write;
  logic [s_sets-1:0] r_valid;
  logic [s_sets-1:0] r_dirty;
  logic [s_tag-1:0]  r_tag_arr  [s_sets];
  logic [s_line-1:0] r_data_arr [s_sets];
  logic [s_line-1:0] r_line;

  logic [s_tag-1:0]   w_in_tag;
  logic [s_index-1:0] w_in_idx;
  logic [s_tag-1:0]   w_victim_tag;
  logic               w_req;
  logic               w_hit;
  logic               w_victim_dirty;
  logic               w_install;
  logic               w_read_hit;
  logic               w_fill_done;
  logic               w_array_we;
  logic [s_line-1:0]  w_array_wdata;

  assign w_in_tag       = bus.mem_address[31 -: s_tag];
  assign w_in_idx       = bus.mem_address[s_offset +: s_index];
  assign w_req          = bus.mem_read | bus.mem_write;
  assign w_victim_tag   = r_tag_arr[r_req_idx];
  assign w_hit          = r_valid[r_req_idx] && (w_victim_tag == r_req_tag);
  assign w_victim_dirty = r_valid[r_req_idx] && r_dirty[r_req_idx];

  // A write that hits, or misses on a clean/invalid line, installs the whole line without a fill.
  assign w_install   = (r_state == ST_TAG_CHECK) && r_req_write && (w_hit || !w_victim_dirty);
  assign w_read_hit  = (r_state == ST_TAG_CHECK) && !r_req_write && w_hit;
  assign w_fill_done = (r_state == ST_FILL) && bus.pmem_resp;
  assign w_array_we  = rst_n && (w_install || w_fill_done);
  assign w_array_wdata = w_fill_done ? bus.pmem_rdata : r_req_wdata;

  assign bus.mem_resp     = w_install || w_read_hit;
  assign bus.mem_rdata    = r_line;
  assign bus.pmem_write   = (r_state == ST_WRITEBACK);
  assign bus.pmem_read    = (r_state == ST_FILL);
  assign bus.pmem_wdata   = r_line;
  assign bus.pmem_address = (r_state == ST_WRITEBACK)
                          ? {w_victim_tag, r_req_idx, {s_offset{1'b0}}}
                          : {r_req_tag,    r_req_idx, {s_offset{1'b0}}};

  // r_line holds data[idx] from the IDLE cycle onward; a fill bypasses the array read.
  always_ff @(posedge clk) begin
    if (w_array_we) begin
      r_data_arr[r_req_idx] <= w_array_wdata;
      r_tag_arr[r_req_idx]  <= r_req_tag;
    end
    if (w_fill_done) begin
      r_line <= bus.pmem_rdata;
    end else if (r_state == ST_IDLE) begin
      r_line <= r_data_arr[w_in_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_req_tag   <= w_in_tag;
            r_req_idx   <= w_in_idx;
            r_req_wdata <= bus.mem_wdata;
            r_req_write <= bus.mem_write;
            r_state     <= ST_TAG_CHECK;
          end
        end
        ST_TAG_CHECK: begin
          if (w_install) begin
            r_valid[r_req_idx] <= 1'b1;
            r_dirty[r_req_idx] <= 1'b1;
            r_state            <= ST_IDLE;
          end else if (w_read_hit) begin
            r_state <= ST_IDLE;
          end else if (w_victim_dirty) begin
            r_state <= ST_WRITEBACK;
          end else begin
            r_state <= ST_FILL;
          end
        end
        ST_WRITEBACK: begin
          if (bus.pmem_resp) begin
            r_dirty[r_req_idx] <= 1'b0;
            r_state            <= r_req_write ? ST_TAG_CHECK : ST_FILL;
          end
        end
        ST_FILL: begin
          if (bus.pmem_resp) begin
            r_valid[r_req_idx] <= 1'b1;
            r_dirty[r_req_idx] <= 1'b0;
            r_state            <= ST_TAG_CHECK;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_l2_cache.sv
// Directed bench for l2_cache: a table of upstream requests with hand-derived pmem traffic,
// latency and read data, plus hand sequences for reset behaviour.
module tb_l2_cache;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_miss = 0;

  l2_cache_if bus ();

  l2_cache dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [255:0] wdata;
    int          delay;
    int          exp_lat;
    bit          exp_wb;
    logic [31:0] exp_wb_addr;
    logic [255:0] exp_wb_data;
    bit          exp_fill;
    logic [31:0] exp_fill_addr;
    logic [255:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];
  logic [255:0] backing [logic [31:0]];

  function automatic logic [255:0] pat(input logic [31:0] a);
    return {8{a ^ 32'hA5A5_0000}};
  endfunction

  function automatic vec_t mk(input bit rd, input bit wr, input logic [31:0] addr,
                              input logic [255:0] wd, input int d, input int lat,
                              input bit wb, input logic [31:0] wba, input logic [255:0] wbd,
                              input bit fill, input logic [31:0] fa, input logic [255:0] rdata);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wd; v.delay = d; v.exp_lat = lat;
    v.exp_wb = wb; v.exp_wb_addr = wba; v.exp_wb_data = wbd;
    v.exp_fill = fill; v.exp_fill_addr = fa; v.exp_rdata = rdata;
    return v;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset_pulse(input bit do_check);
    @(negedge clk);
    rst_n = 1'b0;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.pmem_resp = 1'b0;
    @(negedge clk);
    if (do_check) begin
      check("reset.mem_resp", 256'(bus.mem_resp), 256'd0);
      check("reset.pmem_read", 256'(bus.pmem_read), 256'd0);
      check("reset.pmem_write", 256'(bus.pmem_write), 256'd0);
    end
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    bit got = 0, stable = 1, prev_req = 0, saw_wb = 0, saw_fill = 0;
    int lat = 0, hold = 0;
    logic [31:0] held_addr = '0, wb_addr = '0, fill_addr = '0;
    logic [255:0] rdata = '0, wb_data = '0;
    @(negedge clk);
    bus.mem_read = v.rd;
    bus.mem_write = v.wr;
    bus.mem_address = v.addr;
    bus.mem_wdata = v.wdata;
    for (int c = 1; c <= 300 && !got; c++) begin
      @(negedge clk);
      bus.pmem_resp = 1'b0;
      if (bus.pmem_read && bus.pmem_write) stable = 0;
      if (bus.mem_resp) begin
        got = 1;
        lat = c;
        rdata = bus.mem_rdata;
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
      end else if (bus.pmem_read || bus.pmem_write) begin
        if (!prev_req) begin
          hold = 0;
          held_addr = bus.pmem_address;
          if (bus.pmem_write) begin
            saw_wb = 1; wb_addr = bus.pmem_address; wb_data = bus.pmem_wdata;
          end else begin
            saw_fill = 1; fill_addr = bus.pmem_address;
          end
        end else if (bus.pmem_address !== held_addr) begin
          stable = 0;
        end
        hold++;
        prev_req = 1;
        if (hold == v.delay) begin
          bus.pmem_resp = 1'b1;
          prev_req = 0;
          if (bus.pmem_write) backing[bus.pmem_address] = bus.pmem_wdata;
          else bus.pmem_rdata = backing.exists(bus.pmem_address) ? backing[bus.pmem_address]
                                                                 : pat(bus.pmem_address);
        end
      end else begin
        prev_req = 0;
      end
    end
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    check($sformatf("v%0d.resp", id), 256'(got), 256'd1);
    check($sformatf("v%0d.latency", id), 256'(lat), 256'(v.exp_lat));
    check($sformatf("v%0d.stable", id), 256'(stable), 256'd1);
    check($sformatf("v%0d.wb_seen", id), 256'(saw_wb), 256'(v.exp_wb));
    check($sformatf("v%0d.fill_seen", id), 256'(saw_fill), 256'(v.exp_fill));
    if (v.exp_wb) begin
      check($sformatf("v%0d.wb_addr", id), 256'(wb_addr), 256'(v.exp_wb_addr));
      check($sformatf("v%0d.wb_data", id), wb_data, v.exp_wb_data);
    end
    if (v.exp_fill) check($sformatf("v%0d.fill_addr", id), 256'(fill_addr), 256'(v.exp_fill_addr));
    if (v.rd && !v.wr) check($sformatf("v%0d.rdata", id), rdata, v.exp_rdata);
  endtask

  initial begin
    logic [255:0] line_b, line_c, line_d, line_e, line_f, line_g;
    bit seen;
    line_b = {8{32'hBBBB_0001}};
    line_c = {8{32'hCCCC_0002}};
    line_d = {8{32'hDDDD_0003}};
    line_e = {8{32'hEEEE_0004}};
    line_f = {8{32'hFFFF_0005}};
    line_g = {8{32'h1234_0006}};
    bus.mem_read = 0; bus.mem_write = 0; bus.mem_address = '0; bus.mem_wdata = '0;
    bus.pmem_resp = 0; bus.pmem_rdata = '0;

    //        rd wr addr           wdata   d   lat wb wb_addr        wb_data fill fill_addr    rdata
    vecs.push_back(mk(1, 0, 32'h0000_0040, '0,     5,  7, 0, '0,          '0,     1, 32'h0000_0040, pat(32'h40)));
    vecs.push_back(mk(1, 0, 32'h0000_0044, '0,     1,  1, 0, '0,          '0,     0, '0,            pat(32'h40)));
    vecs.push_back(mk(0, 1, 32'h0000_0040, line_b, 1,  1, 0, '0,          '0,     0, '0,            '0));
    vecs.push_back(mk(1, 0, 32'h0000_0240, '0,     3,  8, 1, 32'h0000_0040, line_b, 1, 32'h0000_0240, pat(32'h240)));
    vecs.push_back(mk(0, 1, 32'h0000_0080, line_c, 1,  1, 0, '0,          '0,     0, '0,            '0));
    vecs.push_back(mk(1, 0, 32'h0000_0280, '0,     2,  6, 1, 32'h0000_0080, line_c, 1, 32'h0000_0280, pat(32'h280)));
    vecs.push_back(mk(1, 0, 32'h0000_0040, '0,     2,  4, 0, '0,          '0,     1, 32'h0000_0040, line_b));
    vecs.push_back(mk(0, 1, 32'h0000_02C0, line_d, 1,  1, 0, '0,          '0,     0, '0,            '0));
    vecs.push_back(mk(0, 1, 32'h0000_06C0, line_e, 4,  6, 1, 32'h0000_02C0, line_d, 0, '0,            '0));
    vecs.push_back(mk(1, 0, 32'h0000_06C4, '0,     1,  1, 0, '0,          '0,     0, '0,            line_e));
    vecs.push_back(mk(1, 1, 32'h0000_0100, line_f, 1,  1, 0, '0,          '0,     0, '0,            '0));
    vecs.push_back(mk(1, 0, 32'h0000_0100, '0,     1,  1, 0, '0,          '0,     0, '0,            line_f));
    vecs.push_back(mk(0, 1, 32'h0000_0284, line_g, 1,  1, 0, '0,          '0,     0, '0,            '0));
    vecs.push_back(mk(1, 0, 32'h0000_0080, '0,     2,  6, 1, 32'h0000_0280, line_g, 1, 32'h0000_0080, line_c));
    vecs.push_back(mk(1, 0, 32'h0000_00A0, '0,    20, 22, 0, '0,          '0,     1, 32'h0000_00A0, pat(32'hA0)));

    do_reset_pulse(1);
    foreach (vecs[i]) run_vec(vecs[i], i);

    // Reset while a fill is outstanding, then a stray pmem_resp in IDLE.
    do_reset_pulse(0);
    @(negedge clk);
    bus.mem_read = 1'b1;
    bus.mem_address = 32'h0000_0040;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = bus.pmem_read;
    end
    check("rstfill.pmem_read_seen", 256'(seen), 256'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    bus.mem_read = 1'b0;
    @(negedge clk);
    check("rstfill.pmem_read", 256'(bus.pmem_read), 256'd0);
    check("rstfill.mem_resp", 256'(bus.mem_resp), 256'd0);
    rst_n = 1'b1;
    bus.pmem_resp = 1'b1;
    bus.pmem_rdata = line_d;
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    check("stray.mem_resp", 256'(bus.mem_resp), 256'd0);
    check("stray.pmem_read", 256'(bus.pmem_read), 256'd0);
    check("stray.pmem_write", 256'(bus.pmem_write), 256'd0);
    run_vec(mk(1, 0, 32'h0000_0040, '0, 2, 4, 0, '0, '0, 1, 32'h0000_0040, line_b), 99);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end
endmodule
